// File: rtl/florencio_gen.sv
// florencio_gen: enumerates every 4-bit invitation set {Diana,Carmen,Bea,Ana}
// that satisfies the guest constraints, one candidate per cycle, and hands
// each valid set to a consumer through a valid/ready handshake.
//
// Parameters:
//   ORDER   0 = scan 0000 -> 1111, 1 = scan 1111 -> 0000
// Ports:
//   clk      system clock, rising edge
//   reset_n  asynchronous active-low reset
//   start    request one enumeration (sampled only in IDLE)
//   ready    consumer accepts the current choice
//   valid    choice holds a valid invitation set (registered)
//   choice   invitation set, bit0 Ana, bit1 Bea, bit2 Carmen, bit3 Diana
//   busy     enumeration in progress (registered)
//   done     one-cycle completion pulse (registered)
//   count    choices accepted in the current/most recent enumeration
// Configuration:
//   FLORENCIO_GEN_COUNT_EN  defined: count is a live handshake counter;
//                           undefined: count is tied to zero.
module florencio_gen #(
    parameter int unsigned ORDER = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] choice,
    output logic       busy,
    output logic       done,
    output logic [2:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        OUT,
        DONE
    } state_t;

    localparam logic [3:0] FIRST_CAND = (ORDER == 0) ? 4'b0000 : 4'b1111;
    localparam logic [3:0] LAST_CAND  = (ORDER == 0) ? 4'b1111 : 4'b0000;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cand;
    logic [3:0] cand_nx;
    logic [3:0] cand_step;
    logic [3:0] choice_nx;
    logic       valid_nx;
    logic       busy_nx;
    logic       done_nx;
    logic       cand_ok;
    logic       cand_last;

    // Constraint check on the live candidate: a=Ana, b=Bea, c=Carmen, d=Diana.
    always_comb begin
        logic a, b, c, d;
        a = cand[0];
        b = cand[1];
        c = cand[2];
        d = cand[3];
        cand_ok = !(a & b & c & d)
                && (a | b | c | d)
                && (!b | c)
                && (!(a & c) | b | d)
                && (!(c | d | !a) | b);
    end

    assign cand_last = (cand == LAST_CAND);
    assign cand_step = (ORDER == 0) ? cand + 4'd1 : cand - 4'd1;

    always_comb begin
        state_nx  = state;
        cand_nx   = cand;
        choice_nx = choice;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = SCAN;
                    cand_nx  = FIRST_CAND;
                end
            end
            SCAN: begin
                if (cand_ok) begin
                    state_nx  = OUT;
                    choice_nx = cand;
                end else if (cand_last) begin
                    state_nx = DONE;
                end else begin
                    cand_nx = cand_step;
                end
            end
            OUT: begin
                if (valid && ready) begin
                    if (cand_last) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = SCAN;
                        cand_nx  = cand_step;
                    end
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Flags are decoded from the next state so they register in step
        // with the state they describe.
        valid_nx = (state_nx == OUT);
        busy_nx  = (state_nx == SCAN) || (state_nx == OUT);
        done_nx  = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            cand   <= '0;
            choice <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_nx;
            cand   <= cand_nx;
            choice <= choice_nx;
            valid  <= valid_nx;
            busy   <= busy_nx;
            done   <= done_nx;
        end
    end

`ifdef FLORENCIO_GEN_COUNT_EN
    logic [2:0] accepted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accepted <= '0;
        end else if (state == IDLE && start) begin
            accepted <= '0;
        end else if (state == OUT && valid && ready) begin
            accepted <= accepted + 3'd1;
        end
    end

    assign count = accepted;
`else
    assign count = '0;
`endif

endmodule

// File: tb/tb_florencio_gen.sv
// tb_florencio_gen: directed bench for florencio_gen. Runs an ascending and a
// descending instance side by side on shared inputs and compares their
// outputs against hand-derived sequences and edge timings.
module tb_florencio_gen;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       ready;

    logic       valid_asc,  valid_desc;
    logic [3:0] choice_asc, choice_desc;
    logic       busy_asc,   busy_desc;
    logic       done_asc,   done_desc;
    logic [2:0] count_asc,  count_desc;

    int unsigned total;
    int unsigned bad;

`ifdef FLORENCIO_GEN_COUNT_EN
    localparam int unsigned EXP_CNT = 4;
`else
    localparam int unsigned EXP_CNT = 0;
`endif

    logic [3:0] exp_asc  [4];
    logic [3:0] exp_desc [4];
    logic [3:0] got_asc  [8];
    logic [3:0] got_desc [8];
    int unsigned n_asc, n_desc;
    int unsigned de_asc, de_desc;

    florencio_gen #(.ORDER(0)) u_dut_asc (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .ready   (ready),
        .valid   (valid_asc),
        .choice  (choice_asc),
        .busy    (busy_asc),
        .done    (done_asc),
        .count   (count_asc)
    );

    florencio_gen #(.ORDER(1)) u_dut_desc (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .ready   (ready),
        .valid   (valid_desc),
        .choice  (choice_desc),
        .busy    (busy_desc),
        .done    (done_desc),
        .count   (count_desc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps up to max_edges edges, logging each handshaken choice and the
    // edge (base + k) after which done is first seen; 0 means never seen.
    task automatic run(input int unsigned base, input int unsigned max_edges);
        n_asc = 0;
        n_desc = 0;
        de_asc = 0;
        de_desc = 0;
        for (int i = 0; i < 8; i++) begin
            got_asc[i] = 4'hF;
            got_desc[i] = 4'hF;
        end
        for (int unsigned k = 1; k <= max_edges; k++) begin
            if (valid_asc && ready) begin
                if (n_asc < 8) got_asc[n_asc] = choice_asc;
                n_asc++;
            end
            if (valid_desc && ready) begin
                if (n_desc < 8) got_desc[n_desc] = choice_desc;
                n_desc++;
            end
            tick();
            if (done_asc && de_asc == 0) de_asc = base + k;
            if (done_desc && de_desc == 0) de_desc = base + k;
            if (de_asc != 0 && de_desc != 0) break;
        end
    endtask

    task automatic check_run(input string tag, input int unsigned exp_edge);
        check({tag, " asc count_out"}, n_asc, 4);
        check({tag, " desc count_out"}, n_desc, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s asc choice[%0d]", tag, i), {28'd0, got_asc[i]}, {28'd0, exp_asc[i]});
            check($sformatf("%s desc choice[%0d]", tag, i), {28'd0, got_desc[i]}, {28'd0, exp_desc[i]});
        end
        check({tag, " asc done edge"}, de_asc, exp_edge);
        check({tag, " desc done edge"}, de_desc, exp_edge);
        check({tag, " asc count"}, {29'd0, count_asc}, EXP_CNT);
        check({tag, " desc count"}, {29'd0, count_desc}, EXP_CNT);
        // one edge later: done pulse over, back in IDLE
        tick();
        check({tag, " asc done drop"}, {31'd0, done_asc}, 0);
        check({tag, " desc done drop"}, {31'd0, done_desc}, 0);
        check({tag, " asc idle busy"}, {31'd0, busy_asc}, 0);
        check({tag, " asc idle count"}, {29'd0, count_asc}, EXP_CNT);
    endtask

    task automatic check_zero(input string tag);
        check({tag, " asc valid"}, {31'd0, valid_asc}, 0);
        check({tag, " asc busy"}, {31'd0, busy_asc}, 0);
        check({tag, " asc done"}, {31'd0, done_asc}, 0);
        check({tag, " asc choice"}, {28'd0, choice_asc}, 0);
        check({tag, " asc count"}, {29'd0, count_asc}, 0);
        check({tag, " desc valid"}, {31'd0, valid_desc}, 0);
        check({tag, " desc busy"}, {31'd0, busy_desc}, 0);
        check({tag, " desc done"}, {31'd0, done_desc}, 0);
        check({tag, " desc choice"}, {28'd0, choice_desc}, 0);
        check({tag, " desc count"}, {29'd0, count_desc}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic found;
        logic seen;
        total = 0;
        bad = 0;
        exp_asc  = '{4'b0001, 4'b0110, 4'b0111, 4'b1110};
        exp_desc = '{4'b1110, 4'b0111, 4'b0110, 4'b0001};
        reset_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;

        // reset state
        #12;
        check_zero("reset");
        tick();
        reset_n = 1'b1;
        tick();
        check_zero("idle");

        // basic enumeration, both scan orders, ready held high
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("first edge1 asc valid", {31'd0, valid_asc}, 0);
        check("first edge1 asc busy", {31'd0, busy_asc}, 1);
        tick();
        check("first edge2 asc valid", {31'd0, valid_asc}, 1);
        check("first edge2 asc choice", {28'd0, choice_asc}, 4'b0001);
        check("first edge2 desc valid", {31'd0, valid_desc}, 1);
        check("first edge2 desc choice", {28'd0, choice_desc}, 4'b1110);
        run(2, 40);
        check_run("basic", 20);

        // consumer stall on the first choice
        start = 1'b1;
        tick();
        start = 1'b0;
        ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("stall%0d asc valid", i), {31'd0, valid_asc}, 1);
            check($sformatf("stall%0d asc choice", i), {28'd0, choice_asc}, 4'b0001);
            check($sformatf("stall%0d desc choice", i), {28'd0, choice_desc}, 4'b1110);
            tick();
        end
        ready = 1'b1;
        run(7, 60);
        check_run("stall", 25);

        // start held high across a whole run
        start = 1'b1;
        tick();
        run(0, 40);
        check_run("held", 20);
        tick();
        check("held restart asc busy", {31'd0, busy_asc}, 1);
        check("held restart desc busy", {31'd0, busy_desc}, 1);
        start = 1'b0;
        run(0, 40);
        check_run("held2", 20);

        // reset while 0110 is pending on the ascending instance
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (valid_asc && choice_asc == 4'b0110) begin
                found = 1'b1;
                break;
            end
        end
        check("abort reached 0110", {31'd0, found}, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("abort");
        tick();
        tick();
        reset_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_asc || done_asc || valid_desc || done_desc || busy_asc || busy_desc) seen = 1'b1;
        end
        check("abort quiet", {31'd0, seen}, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        run(0, 40);
        check_run("fresh", 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/florencio_gen.md
FLORENCIO_GEN -- requirements
Module: florencio_gen

Interface
REQ-001 Parameter: ORDER, default 0, candidate scan order (0 = ascending 0000->1111, 1 = descending 1111->0000).
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request one full enumeration; sampled only in IDLE.
REQ-005 Port: ready  input  1  consumer accepts the current choice.
REQ-006 Port: valid  output  1  choice holds a valid invitation set.
REQ-007 Port: choice  output  4  invitation set {d,c,b,a}: bit0 Ana, bit1 Bea, bit2 Carmen, bit3 Diana; 1 = invited.
REQ-008 Port: busy  output  1  enumeration in progress (state SCAN or OUT).
REQ-009 Port: done  output  1  one-cycle pulse when the enumeration completes.
REQ-010 Port: count  output  3  number of choices accepted in the current or most recent enumeration.

Function
REQ-011 A candidate SHALL be valid iff all hold: not all four invited; at least one invited; b->c; (a&c)->(b|d); (c|d|!a)->b.
REQ-012 The valid set SHALL be exactly {0001, 0110, 0111, 1110}, decided internally from REQ-011 (no lookup table).
REQ-013 FSM states SHALL be IDLE, SCAN, OUT and DONE.
REQ-014 IDLE: start=1 -> SCAN, candidate loaded with 0000 (ORDER=0) or 1111 (ORDER=1); start=0 -> stay in IDLE.
REQ-015 SCAN: one candidate is evaluated per cycle; valid -> OUT with choice=candidate; invalid and not last -> step the candidate by one in scan order; invalid and last -> DONE.
REQ-016 OUT: valid=1; choice stays stable while ready=0; a handshake is valid&ready at a rising edge.
REQ-017 OUT on handshake: last candidate -> DONE; otherwise step the candidate and return to SCAN.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE unconditionally.
REQ-019 The candidate counter SHALL be 4 bits wide; it never wraps during an enumeration because the last candidate ends the scan.
REQ-020 ready SHALL be ignored outside OUT; start SHALL be ignored outside IDLE, including start held high.
REQ-021 First valid SHALL assert 2 cycles after the start-sampling edge (ORDER=0).
REQ-022 With ready held at 1, done SHALL be high in the cycle following the 20th edge after the start-sampling edge, for both ORDER values.
REQ-023 valid, busy and done SHALL be registered outputs.

Reset
REQ-024 reset_n=0 SHALL immediately force: state IDLE, valid=0, busy=0, done=0, choice=0000, count=0, candidate=0000.
REQ-025 Reset mid-enumeration SHALL abort with no further valid or done until a new start is sampled.

Configuration
REQ-026 Macro FLORENCIO_GEN_COUNT_EN defined: count is cleared on start acceptance and incremented on each handshake, and holds its value in IDLE.
REQ-027 Macro FLORENCIO_GEN_COUNT_EN undefined: count is tied to 0 and no counter register exists; the port list is unchanged.

Verification
REQ-028 ORDER=0, ready=1, one start pulse -> choices 0001, 0110, 0111, 1110 in that order; done 20 edges after start; count=4 (macro defined).
REQ-029 ORDER=1, ready=1 -> choices 1110, 0111, 0110, 0001; done 20 edges after start.
REQ-030 ready=0 for 5 cycles while first valid is high -> choice stays 0001 and valid stays 1; one handshake when ready=1; no duplicate output.
REQ-031 start held at 1 for the whole run -> exactly one enumeration, then a new one starts from IDLE after done.
REQ-032 reset_n pulsed low while choice=0110 is pending -> all outputs reset immediately; no done; a fresh start reproduces the full REQ-028 sequence.
REQ-033 Macro undefined -> count=0 throughout the REQ-028 run.
